sweep_sched: RTL and testbench
==============================

SWEEP_SCHED -- requirements
Module: sweep_sched

Interface
REQ-001 Parameter: DAC_W, 14, DAC code width.
REQ-002 Parameter: SETTLE_CYC, 16, laser settle cycles before each ramp (range 1..255).
REQ-003 Parameter: CFG_BASE, 8'd16, address of the first configuration register.
REQ-004 Port: clk_i  input  1  single system clock; all logic on its rising edge.
REQ-005 Port: rst_i  input  1  reset, synchronous, active-high.
REQ-006 Port: temp_good_i  input  1  laser temperature in range.
REQ-007 Port: cfg_addr_i  input  10  constant-bus address; write strobe when bits [9:8]==2'b11.
REQ-008 Port: cfg_data_i  input  65  constant-bus write data.
REQ-009 Port: start_i  input  1  start request, level-sampled in IDLE.
REQ-010 Port: abort_i  input  1  abort active sweep / acknowledge fault.
REQ-011 Port: dac_o  output  DAC_W  laser DAC code.
REQ-012 Port: vcsel_o_n  output  1  laser enable, active-low.
REQ-013 Port: run_stb_o  output  1  one-cycle pulse on first RAMP cycle.
REQ-014 Port: sweep_done_o  output  1  one-cycle pulse on last RAMP cycle.
REQ-015 Port: busy_o  output  1  high in SETTLE or RAMP.
REQ-016 Port: fault_o  output  1  high in FAULT.
REQ-017 Port: cfg_err_o  output  1  one-cycle pulse on rejected start.

Function
REQ-018 Registers, write when cfg_addr_i[9:8]==2'b11 and cfg_addr_i[7:0] matches: CFG_BASE+0 SWEEP_MIN=data[DAC_W-1:0]; +1 SWEEP_MAX=data[DAC_W-1:0]; +2 SWEEP_STEP=data[DAC_W-1:0]; +3 SWEEP_COUNT=data[15:0]; other addresses ignored.
REQ-019 Register writes accepted only in IDLE; writes in any other state are dropped.
REQ-020 States: IDLE, SETTLE, RAMP, FAULT; all outputs registered.
REQ-021 IDLE: vcsel_o_n=1, dac_o=0, busy_o=0; start_i=1 with temp_good_i=1, MIN<=MAX, STEP!=0 -> SETTLE next cycle, sweep counter cleared.
REQ-022 start_i=1 in IDLE with MIN>MAX or STEP==0 -> stay IDLE, cfg_err_o=1 for one cycle; temp_good_i=0 -> stay IDLE, no error.
REQ-023 SETTLE: vcsel_o_n=0, dac_o=MIN, lasts exactly SETTLE_CYC cycles, then RAMP.
REQ-024 RAMP first cycle: dac_o=MIN, run_stb_o=1; each following cycle dac_o=min(dac_o+STEP, MAX), sum computed in DAC_W+1 bits (no wrap).
REQ-025 RAMP cycle with dac_o==MAX is last: sweep_done_o=1, sweep counter +1 (16-bit).
REQ-026 After last RAMP cycle: counter==SWEEP_COUNT and SWEEP_COUNT!=0 -> IDLE; else SETTLE (next sweep). SWEEP_COUNT=0 means continuous.
REQ-027 MIN==MAX: RAMP lasts one cycle with run_stb_o and sweep_done_o both high.
REQ-028 abort_i=1 in SETTLE or RAMP -> IDLE next cycle; no sweep_done_o pulse.
REQ-029 temp_good_i=0 in SETTLE or RAMP -> FAULT next cycle; has priority over abort_i and sweep completion.
REQ-030 FAULT: vcsel_o_n=1, dac_o=0, fault_o=1; exit to IDLE only when abort_i=1 and temp_good_i=1 in same cycle.
REQ-031 start_i ignored outside IDLE.

Reset
REQ-032 rst_i=1 at any clock edge, including mid-sweep: state IDLE, dac_o=0, vcsel_o_n=1, run_stb_o=0, sweep_done_o=0, busy_o=0, fault_o=0, cfg_err_o=0, counters 0.
REQ-033 Register reset values: MIN=0, MAX=2**DAC_W-1, STEP=1, COUNT=1.

Verification
REQ-034 MIN=100, MAX=110, STEP=4, COUNT=1, start -> SETTLE 16 cycles at 100, dac_o 100,104,108,110, run_stb with 100, done with 110, then IDLE, vcsel_o_n=1.
REQ-035 COUNT=2, same config -> two sweeps separated by 16 SETTLE cycles, two run_stb and two done pulses, then IDLE.
REQ-036 temp_good_i=0 mid-RAMP -> next cycle fault_o=1, dac_o=0, vcsel_o_n=1; abort_i with temp_good_i=1 -> IDLE.
REQ-037 MIN=200, MAX=100, start -> cfg_err_o single pulse, stays IDLE; write of MIN during RAMP -> value unchanged afterward.
REQ-038 rst_i=1 mid-RAMP -> next cycle all outputs at reset values, registers at reset defaults.
REQ-039 COUNT=0, MIN=MAX=50 -> continuous one-cycle ramps every 17 cycles until abort_i; abort -> IDLE, no further done pulse.

Source files
------------

// File: rtl/sweep_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sweep_sched: laser DAC sweep scheduler (settle, ramp, repeat, fault)     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module sweep_sched #(
  parameter int         DAC_W      = 14,
  parameter int         SETTLE_CYC = 16,
  parameter logic [7:0] CFG_BASE   = 8'd16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             temp_good_i,
  input  logic [9:0]       cfg_addr_i,
  input  logic [64:0]      cfg_data_i,
  input  logic             start_i,
  input  logic             abort_i,
  output logic [DAC_W-1:0] dac_o,
  output logic             vcsel_o_n,
  output logic             run_stb_o,
  output logic             sweep_done_o,
  output logic             busy_o,
  output logic             fault_o,
  output logic             cfg_err_o
);

  localparam logic [7:0] ADDR_MIN    = CFG_BASE;
  localparam logic [7:0] ADDR_MAX    = CFG_BASE + 8'd1;
  localparam logic [7:0] ADDR_STEP   = CFG_BASE + 8'd2;
  localparam logic [7:0] ADDR_COUNT  = CFG_BASE + 8'd3;
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RAMP   = 2'd2,
    FAULT  = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [DAC_W-1:0] sweep_min, sweep_max, sweep_step;
  logic [15:0]      sweep_count;
  logic [7:0]       settle_cnt, settle_cnt_nxt;
  logic [15:0]      sweep_cnt, sweep_cnt_nxt;
  logic [DAC_W-1:0] dac_nxt;
  logic [DAC_W:0]   ramp_sum;
  logic             run_stb_nxt, done_nxt, cfg_err_nxt;
  logic             busy_nxt, fault_nxt;
  logic             bad_cfg;
  logic             unused_cfg_bits;

  assign unused_cfg_bits = &{1'b0, cfg_data_i[64:16]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sweep_min   <= '0;
      sweep_max   <= '1;
      sweep_step  <= DAC_W'(1);
      sweep_count <= 16'd1;
    end else if (state == IDLE && cfg_addr_i[9:8] == 2'b11) begin
      case (cfg_addr_i[7:0])
        ADDR_MIN:   sweep_min   <= cfg_data_i[DAC_W-1:0];
        ADDR_MAX:   sweep_max   <= cfg_data_i[DAC_W-1:0];
        ADDR_STEP:  sweep_step  <= cfg_data_i[DAC_W-1:0];
        ADDR_COUNT: sweep_count <= cfg_data_i[15:0];
        default:    ;
      endcase
    end
  end

  always_comb begin
    state_nxt      = state;
    settle_cnt_nxt = settle_cnt;
    sweep_cnt_nxt  = sweep_cnt;
    dac_nxt        = dac_o;
    run_stb_nxt    = 1'b0;
    done_nxt       = 1'b0;
    cfg_err_nxt    = 1'b0;
    ramp_sum       = {1'b0, dac_o} + {1'b0, sweep_step};
    bad_cfg        = (sweep_min > sweep_max) || (sweep_step == '0);

    case (state)
      IDLE: begin
        if (start_i) begin
          if (bad_cfg) begin
            cfg_err_nxt = 1'b1;
          end else if (temp_good_i) begin
            state_nxt      = SETTLE;
            settle_cnt_nxt = '0;
            sweep_cnt_nxt  = '0;
          end
        end
      end
      SETTLE: begin
        if (!temp_good_i) begin
          state_nxt = FAULT;
        end else if (abort_i) begin
          state_nxt = IDLE;
        end else if (settle_cnt == SETTLE_LAST) begin
          state_nxt   = RAMP;
          dac_nxt     = sweep_min;
          run_stb_nxt = 1'b1;
          done_nxt    = (sweep_min == sweep_max);
          if (done_nxt) sweep_cnt_nxt = sweep_cnt + 16'd1;
        end else begin
          settle_cnt_nxt = settle_cnt + 8'd1;
        end
      end
      RAMP: begin
        if (!temp_good_i) begin
          state_nxt = FAULT;
        end else if (abort_i) begin
          state_nxt = IDLE;
        end else if (dac_o == sweep_max) begin
          // Counter was already bumped when the done pulse was scheduled.
          if (sweep_count != 16'd0 && sweep_cnt == sweep_count) begin
            state_nxt = IDLE;
          end else begin
            state_nxt      = SETTLE;
            settle_cnt_nxt = '0;
          end
        end else begin
          if (ramp_sum > {1'b0, sweep_max}) dac_nxt = sweep_max;
          else                              dac_nxt = ramp_sum[DAC_W-1:0];
          done_nxt = (dac_nxt == sweep_max);
          if (done_nxt) sweep_cnt_nxt = sweep_cnt + 16'd1;
        end
      end
      FAULT: begin
        if (abort_i && temp_good_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (state_nxt == IDLE || state_nxt == FAULT) dac_nxt = '0;
    else if (state_nxt == SETTLE)                dac_nxt = sweep_min;
    busy_nxt  = (state_nxt == SETTLE) || (state_nxt == RAMP);
    fault_nxt = (state_nxt == FAULT);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      settle_cnt   <= '0;
      sweep_cnt    <= '0;
      dac_o        <= '0;
      vcsel_o_n    <= 1'b1;
      run_stb_o    <= 1'b0;
      sweep_done_o <= 1'b0;
      busy_o       <= 1'b0;
      fault_o      <= 1'b0;
      cfg_err_o    <= 1'b0;
    end else begin
      state        <= state_nxt;
      settle_cnt   <= settle_cnt_nxt;
      sweep_cnt    <= sweep_cnt_nxt;
      dac_o        <= dac_nxt;
      vcsel_o_n    <= !busy_nxt;
      run_stb_o    <= run_stb_nxt;
      sweep_done_o <= done_nxt;
      busy_o       <= busy_nxt;
      fault_o      <= fault_nxt;
      cfg_err_o    <= cfg_err_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sweep_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sweep_sched: directed bench for sweep_sched with a behavioural model  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_sweep_sched;

  localparam int DAC_W      = 14;
  localparam int SETTLE_CYC = 16;
  localparam int P_IDLE = 0, P_SETTLE = 1, P_RAMP = 2, P_FAULT = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             temp_good = 1'b1;
  logic [9:0]       cfg_addr = '0;
  logic [64:0]      cfg_data = '0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [DAC_W-1:0] dac;
  logic             vcsel_n, run_stb, sweep_done, busy, fault, cfg_err;

  sweep_sched #(.DAC_W(DAC_W), .SETTLE_CYC(SETTLE_CYC), .CFG_BASE(8'd16)) dut (
    .clk_i(clk), .rst_i(rst), .temp_good_i(temp_good), .cfg_addr_i(cfg_addr),
    .cfg_data_i(cfg_data), .start_i(start), .abort_i(abort), .dac_o(dac),
    .vcsel_o_n(vcsel_n), .run_stb_o(run_stb), .sweep_done_o(sweep_done),
    .busy_o(busy), .fault_o(fault), .cfg_err_o(cfg_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: phase, settle cycles left, ramp step index, sweeps finished.
  int m_phase = P_IDLE, m_left = 0, m_k = 0, m_sweeps = 0;
  int m_min = 0, m_max = 16383, m_step = 1, m_count = 1;
  int m_err = 0;

  // Monitor statistics for literal checks.
  int cyc = 0, n_run = 0, n_done = 0, n_busy = 0;
  int run_dac = -1, done_dac = -1, first_run_cyc = -1, last_run_cyc = -1;

  function automatic int ramp_val(int k);
    int v;
    v = m_min + k * m_step;
    return (v > m_max) ? m_max : v;
  endfunction

  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic model_step();
    int  cur;
    bit  was_idle;
    m_err = 0;
    if (rst) begin
      m_phase = P_IDLE; m_sweeps = 0;
      m_min = 0; m_max = (1 << DAC_W) - 1; m_step = 1; m_count = 1;
    end else begin
      was_idle = (m_phase == P_IDLE);
      case (m_phase)
        P_IDLE: if (start) begin
          if (m_min > m_max || m_step == 0) m_err = 1;
          else if (temp_good) begin
            m_phase = P_SETTLE; m_left = SETTLE_CYC; m_sweeps = 0;
          end
        end
        P_SETTLE: begin
          if (!temp_good)      m_phase = P_FAULT;
          else if (abort)      m_phase = P_IDLE;
          else if (m_left == 1) begin m_phase = P_RAMP; m_k = 0; end
          else                 m_left--;
        end
        P_RAMP: begin
          cur = ramp_val(m_k);
          if (!temp_good)      m_phase = P_FAULT;
          else if (abort)      m_phase = P_IDLE;
          else if (cur == m_max) begin
            m_sweeps = (m_sweeps + 1) % 65536;
            if (m_count != 0 && m_sweeps == m_count) m_phase = P_IDLE;
            else begin m_phase = P_SETTLE; m_left = SETTLE_CYC; end
          end else m_k++;
        end
        default: if (abort && temp_good) m_phase = P_IDLE;
      endcase
      if (was_idle && cfg_addr[9:8] == 2'b11) begin
        case (int'(cfg_addr[7:0]))
          16: m_min   = int'(cfg_data[DAC_W-1:0]);
          17: m_max   = int'(cfg_data[DAC_W-1:0]);
          18: m_step  = int'(cfg_data[DAC_W-1:0]);
          19: m_count = int'(cfg_data[15:0]);
          default: ;
        endcase
      end
    end
  endtask

  task automatic compare();
    int  e_dac;
    bit  act;
    act   = (m_phase == P_SETTLE) || (m_phase == P_RAMP);
    e_dac = (m_phase == P_SETTLE) ? m_min : (m_phase == P_RAMP) ? ramp_val(m_k) : 0;
    chk("dac",        int'(dac),        e_dac);
    chk("vcsel_n",    int'(vcsel_n),    act ? 0 : 1);
    chk("run_stb",    int'(run_stb),    (m_phase == P_RAMP && m_k == 0) ? 1 : 0);
    chk("sweep_done", int'(sweep_done), (m_phase == P_RAMP && ramp_val(m_k) == m_max) ? 1 : 0);
    chk("busy",       int'(busy),       act ? 1 : 0);
    chk("fault",      int'(fault),      (m_phase == P_FAULT) ? 1 : 0);
    chk("cfg_err",    int'(cfg_err),    m_err);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare();
    cyc++;
    if (busy) n_busy++;
    if (run_stb) begin
      n_run++; run_dac = int'(dac);
      if (first_run_cyc < 0) first_run_cyc = cyc;
      last_run_cyc = cyc;
    end
    if (sweep_done) begin n_done++; done_dac = int'(dac); end
  endtask

  task automatic clr();
    cyc = 0; n_run = 0; n_done = 0; n_busy = 0;
    run_dac = -1; done_dac = -1; first_run_cyc = -1; last_run_cyc = -1;
  endtask

  task automatic wr(input int off, input int d);
    cfg_addr = {2'b11, 8'(16 + off)};
    cfg_data = 65'(d);
    tick();
    cfg_addr = '0;
    cfg_data = '0;
  endtask

  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_dac", int'(dac), 0);
    chk("rst_vcsel_n", int'(vcsel_n), 1);

    // Single sweep 100..110 step 4
    wr(0, 100); wr(1, 110); wr(2, 4); wr(3, 1);
    clr(); go(); repeat (30) tick();
    chk("s1_runs", n_run, 1);       chk("s1_run_dac", run_dac, 100);
    chk("s1_dones", n_done, 1);     chk("s1_done_dac", done_dac, 110);
    chk("s1_busy_cycles", n_busy, 20);
    chk("s1_end_vcsel_n", int'(vcsel_n), 1);

    // Two sweeps
    wr(3, 2);
    clr(); go(); repeat (50) tick();
    chk("s2_runs", n_run, 2); chk("s2_dones", n_done, 2);
    chk("s2_busy_cycles", n_busy, 40);

    // MIN write during RAMP is dropped
    wr(3, 1);
    go(); repeat (16) tick();
    chk("wr_in_ramp_run", int'(run_stb), 1);
    wr(0, 5);
    repeat (20) tick();
    go();
    chk("min_kept", int'(dac), 100);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_settle_idle", int'(busy), 0);

    // Start with temperature bad: no error, stays idle
    temp_good = 1'b0; go(); temp_good = 1'b1;
    chk("cold_start_err", int'(cfg_err), 0);
    chk("cold_start_busy", int'(busy), 0);

    // Fault mid-ramp and recovery
    go(); repeat (18) tick();
    temp_good = 1'b0; tick();
    chk("fault_flag", int'(fault), 1); chk("fault_dac", int'(dac), 0);
    chk("fault_vcsel_n", int'(vcsel_n), 1);
    abort = 1'b1; tick();
    chk("fault_hold", int'(fault), 1);
    temp_good = 1'b1; tick(); abort = 1'b0;
    chk("fault_exit", int'(fault), 0);
    repeat (3) tick();

    // Abort mid-ramp one cycle before the last: no done pulse
    clr(); go(); repeat (18) tick();
    abort = 1'b1; tick(); abort = 1'b0;
    repeat (5) tick();
    chk("abort_no_done", n_done, 0);

    // Rejected starts
    wr(0, 200); wr(1, 100);
    go();
    chk("err_minmax", int'(cfg_err), 1);
    tick();
    chk("err_pulse_len", int'(cfg_err), 0);
    wr(0, 100); wr(1, 110); wr(2, 0);
    go();
    chk("err_step0", int'(cfg_err), 1);
    tick();
    wr(2, 4);

    // Reset mid-ramp restores outputs and register defaults
    go(); repeat (17) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_mid_busy", int'(busy), 0); chk("rst_mid_dac", int'(dac), 0);
    chk("rst_mid_vcsel_n", int'(vcsel_n), 1);
    wr(1, 3);
    clr(); go(); repeat (25) tick();
    chk("dflt_run_dac", run_dac, 0); chk("dflt_done_dac", done_dac, 3);
    chk("dflt_dones", n_done, 1);    chk("dflt_busy_cycles", n_busy, 20);

    // Continuous single-point sweeps until abort
    wr(0, 50); wr(1, 50); wr(3, 0);
    clr(); go(); repeat (72) tick();
    chk("cont_runs", n_run, 4);           chk("cont_dones", n_done, 4);
    chk("cont_first", first_run_cyc, 17); chk("cont_last", last_run_cyc, 68);
    chk("cont_run_dac", run_dac, 50);
    abort = 1'b1; tick(); abort = 1'b0;
    clr(); repeat (40) tick();
    chk("cont_after_abort_done", n_done, 0);
    chk("cont_after_abort_busy", n_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
